// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: data width, alu_op encodings, ALU control codes
// and the store opcode used by the immediate generator.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_ctrl_e;

endpackage

// File: rtl/regfile.sv
// 32 x XLEN register file: two combinational read ports, one write port,
// x0 hardwired to zero, all registers cleared by asynchronous reset.
module regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs [0:31];

    // Reset dominates, so a write pending at the moment rst rises is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs[raddr2_i];

endmodule

// File: rtl/execute_stage.sv
// Single-cycle RV32I execute stage: register file, immediate generator,
// ALU control and ALU. Define EXECUTE_SHIFT_EN to build the barrel shifter.
module execute_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [1:0]      alu_op,
    input  logic            alu_src,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [31:0]     instr,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    alu_ctrl_e       alu_ctrl;
    logic            unused_instr;

    regfile rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we),
        .waddr_i  (rd),
        .wdata_i  (alu_result),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Only store and I-type layouts are needed; everything else reads as I-type.
    assign imm = (instr[6:0] == OPC_STORE)
               ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
               : {{20{instr[31]}}, instr[31:20]};

    assign unused_instr = ^instr[19:12];

    assign op_a  = rd1;
    assign op_b  = alu_src ? imm : rd2;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (funct7_5 && !alu_src) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_AND:  alu_result = op_a & op_b;
`ifdef EXECUTE_SHIFT_EN
            ALU_SLL:  alu_result = op_a << shamt;
            ALU_SRL:  alu_result = op_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
`else
            // Shifts collapse to zero so no shifter is built.
            ALU_SLL:  alu_result = '0;
            ALU_SRL:  alu_result = '0;
            ALU_SRA:  alu_result = '0;
`endif
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: register writes via addi from x0,
// ALU functions, immediates, x0 handling, shifts and asynchronous reset.
module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] instr;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    execute_stage dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .instr      (instr),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .alu_result (alu_result),
        .zero       (zero),
        .rd1        (rd1),
        .rd2        (rd2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // scoreboard: expected ALU result queued, then popped against the DUT
    task automatic expect_alu(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        check(tag, alu_result, exp_q.pop_front());
    endtask

    // driver tasks
    task automatic drive(input logic [1:0] op, input logic src, input logic [2:0] f3,
                         input logic f75, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic w, input logic [31:0] ins);
        alu_op = op; alu_src = src; funct3 = f3; funct7_5 = f75;
        rs1 = a; rs2 = b; rd = d; we = w; instr = ins;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd0, 7'b0010011};
    endfunction

    task automatic wr_imm(input logic [4:0] r, input logic [11:0] imm);
        drive(ALUOP_ADD, 1'b1, 3'b000, 1'b0, 5'd0, 5'd0, r, 1'b1, itype(imm));
        tick();
    endtask

    task automatic rr(input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                      input logic f75);
        drive(ALUOP_FUNCT, 1'b0, f3, f75, a, b, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
        drive(ALUOP_ADD, 1'b0, 3'b000, 1'b0, r, 5'd0, 5'd0, 1'b0, 32'h0);
        check(tag, rd1, v);
    endtask

    initial begin
        rst = 1'b1;
        drive(ALUOP_ADD, 1'b0, 3'b000, 1'b0, 5'd5, 5'd1, 5'd0, 1'b0, 32'h0);
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // preload x1=10, x2=15
        drive(ALUOP_ADD, 1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, itype(12'd10));
        expect_alu("addi_x1_result", 32'd10);
        tick();
        wr_imm(5'd2, 12'd15);
        check_reg("x1_preload", 5'd1, 32'd10);

        drive(ALUOP_FUNCT, 1'b0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 32'h0);
        expect_alu("add_10_15", 32'd25);
        check("add_zero", {31'b0, zero}, 32'd0);
        tick();
        check_reg("wb_x5", 5'd5, 32'd25);

        // read of rd in the write cycle returns the old value
        drive(ALUOP_ADD, 1'b0, 3'b000, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 32'h0);
        check("same_cycle_old", rd1, 32'd25);
        expect_alu("x5_double", 32'd50);
        tick();
        check_reg("after_edge_new", 5'd5, 32'd50);

        rr(5'd1, 5'd2, 3'b000, 1'b1);
        expect_alu("sub_10_15", 32'hFFFF_FFFB);
        rr(5'd1, 5'd2, 3'b100, 1'b0);
        expect_alu("xor", 32'd5);
        rr(5'd1, 5'd2, 3'b110, 1'b0);
        expect_alu("or", 32'd15);
        rr(5'd1, 5'd2, 3'b111, 1'b0);
        expect_alu("and", 32'd10);
        rr(5'd1, 5'd2, 3'b010, 1'b0);
        expect_alu("slt_10_15", 32'd1);
        drive(2'b11, 1'b0, 3'b111, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0);
        expect_alu("aluop11_add", 32'd25);

        // addi x6, x1, -3
        drive(ALUOP_FUNCT, 1'b1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd6, 1'b1, 32'hFFD0_8313);
        expect_alu("addi_neg3", 32'd7);
        tick();
        check_reg("wb_x6", 5'd6, 32'd7);

        // S-type immediate -8 versus the same bits decoded as I-type (-32)
        drive(ALUOP_ADD, 1'b1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 32'hFE00_0C23);
        expect_alu("stype_imm", 32'd2);
        drive(ALUOP_ADD, 1'b1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 32'hFE00_0C13);
        expect_alu("itype_imm", 32'hFFFF_FFEA);

        // signed vs unsigned compare with x8 = -1
        wr_imm(5'd8, 12'hFFF);
        rr(5'd8, 5'd1, 3'b010, 1'b0);
        expect_alu("slt_neg", 32'd1);
        rr(5'd8, 5'd1, 3'b011, 1'b0);
        expect_alu("sltu_neg", 32'd0);

        // writes to x0 are dropped
        drive(ALUOP_ADD, 1'b0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 32'h0);
        expect_alu("x0_write_val", 32'd25);
        tick();
        check_reg("x0_read", 5'd0, 32'd0);
        check("x0_storage", dut.rf.regs[0], 32'd0);

        // SUB with equal operands raises zero
        wr_imm(5'd9, 12'd7);
        wr_imm(5'd10, 12'd7);
        drive(ALUOP_SUB, 1'b0, 3'b000, 1'b0, 5'd9, 5'd10, 5'd0, 1'b0, 32'h0);
        expect_alu("sub_eq", 32'd0);
        check("sub_eq_zero", {31'b0, zero}, 32'd1);

        // build x3 = 0x80000000 by doubling, x4 = 4
        wr_imm(5'd3, 12'd1);
        for (int i = 0; i < 31; i++) begin
            drive(ALUOP_ADD, 1'b0, 3'b000, 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 32'h0);
            tick();
        end
        check_reg("x3_msb", 5'd3, 32'h8000_0000);
        wr_imm(5'd4, 12'd4);
`ifdef EXECUTE_SHIFT_EN
        rr(5'd3, 5'd4, 3'b101, 1'b1);
        expect_alu("sra", 32'hF800_0000);
        rr(5'd3, 5'd4, 3'b101, 1'b0);
        expect_alu("srl", 32'h0800_0000);
        rr(5'd1, 5'd4, 3'b001, 1'b0);
        expect_alu("sll", 32'd160);
`else
        rr(5'd3, 5'd4, 3'b101, 1'b1);
        expect_alu("sra_off", 32'd0);
        rr(5'd3, 5'd4, 3'b101, 1'b0);
        expect_alu("srl_off", 32'd0);
        rr(5'd1, 5'd4, 3'b001, 1'b0);
        expect_alu("sll_off", 32'd0);
        check("sll_off_zero", {31'b0, zero}, 32'd1);
`endif

        // asynchronous reset between edges
        drive(ALUOP_ADD, 1'b0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_rd1", rd1, 32'd0);
        check("async_rst_rd2", rd2, 32'd0);
        drive(ALUOP_ADD, 1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, itype(12'd5));
        expect_alu("rst_alu_imm", 32'd5);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reg("rst_blocks_write", 5'd7, 32'd0);
        check_reg("rst_cleared_x6", 5'd6, 32'd0);
        check("rst_cleared_x3", dut.rf.regs[3], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
